firebird7_in_gate1_tessent_ijtag_host_seq: RTL and testbench

- IJTAG initiator that drives a SIB-based IJTAG network from a simple request/response interface.
- Each accepted request runs one full network access: CAPTURE, N SHIFT cycles, then UPDATE. The block returns the shifted-out bits.
- Sits between the on-die test controller and the top SIB's ijtag_* inputs, and supplies the sel/ce/se/ue/si signals that SIBs consume.

---
 rtl/firebird7_in_gate1_ijtag_host_pkg.sv | 20 ++
 rtl/firebird7_in_gate1_ijtag_host_drive.sv | 35 +++
 rtl/firebird7_in_gate1_tessent_ijtag_host_seq.sv | 138 +++++++++++++
 tb/tb_firebird7_in_gate1_tessent_ijtag_host_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate1_ijtag_host_pkg.sv
// Shared types for the IJTAG host sequencer: FSM states, default sizing and request record.
package firebird7_in_gate1_ijtag_host_pkg;

  localparam int unsigned MaxLenDefault = 64;
  localparam int unsigned CntWDefault   = $clog2(MaxLenDefault + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StShift,
    StUpdate,
    StResp
  } host_state_e;

  typedef struct packed {
    logic [CntWDefault-1:0]   len;
    logic [MaxLenDefault-1:0] wdata;
  } req_t;

endpackage

// File: rtl/firebird7_in_gate1_ijtag_host_drive.sv
// Falling-edge register stage for the network drive signals, cleared asynchronously by reset.
module firebird7_in_gate1_ijtag_host_drive
  import firebird7_in_gate1_ijtag_host_pkg::*;
(
  input  logic tck,
  input  logic reset_n,
  input  logic sel_nxt,
  input  logic ce_nxt,
  input  logic se_nxt,
  input  logic ue_nxt,
  input  logic si_nxt,
  output logic sel,
  output logic ce,
  output logic se,
  output logic ue,
  output logic si
);

  always_ff @(negedge tck or negedge reset_n) begin
    if (!reset_n) begin
      sel <= 1'b0;
      ce  <= 1'b0;
      se  <= 1'b0;
      ue  <= 1'b0;
      si  <= 1'b0;
    end else begin
      sel <= sel_nxt;
      ce  <= ce_nxt;
      se  <= se_nxt;
      ue  <= ue_nxt;
      si  <= si_nxt;
    end
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_ijtag_host_seq.sv
// IJTAG initiator: one request runs CAPTURE, len SHIFT cycles and UPDATE, then returns so bits.
module firebird7_in_gate1_tessent_ijtag_host_seq
  import firebird7_in_gate1_ijtag_host_pkg::*;
#(
  parameter int unsigned MAX_LEN = MaxLenDefault,
  parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CNT_W-1:0]   req_len,
  input  logic [MAX_LEN-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so
);

  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  host_state_e        state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   len_q;
  logic [MAX_LEN-1:0] wdata_q;
  logic [MAX_LEN-1:0] rdata_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;

  logic [CNT_W-1:0]   cnt_inc;
  logic [MAX_LEN-1:0] so_vec;
  logic               len_illegal;
  logic               sel_nxt, ce_nxt, se_nxt, ue_nxt, si_nxt;

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign so_vec      = {{(MAX_LEN-1){1'b0}}, ijtag_so};
  assign len_illegal = (req_len == '0) || (req_len > CNT_W'(MAX_LEN));

  assign req_ready = ijtag_reset && (state_q == StIdle) && !rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            len_q   <= req_len;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            cnt_q   <= '0;
            if (len_illegal) begin
              rsp_err_q <= 1'b1;
              state_q   <= StResp;
            end else begin
              rsp_err_q <= 1'b0;
              state_q   <= StCapture;
            end
          end
        end
        StCapture: state_q <= StShift;
        StShift: begin
          // so seen at this edge is the bit exposed by the previous falling edge
          rdata_q <= rdata_q | (so_vec << cnt_q);
          cnt_q   <= cnt_inc;
          if (cnt_inc == len_q) state_q <= StUpdate;
        end
        StUpdate: state_q <= StResp;
        StResp: begin
          // one cycle gap lets the network finish its falling-edge update before rsp_valid
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    sel_nxt = 1'b0;
    ce_nxt  = 1'b0;
    se_nxt  = 1'b0;
    ue_nxt  = 1'b0;
    si_nxt  = 1'b0;
    case (state_q)
      StCapture: begin
        sel_nxt = 1'b1;
        ce_nxt  = 1'b1;
      end
      StShift: begin
        sel_nxt = 1'b1;
        se_nxt  = 1'b1;
        si_nxt  = wdata_q[cnt_q[IdxW-1:0]];
      end
      StUpdate: begin
        sel_nxt = 1'b1;
        ue_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  firebird7_in_gate1_ijtag_host_drive u_drive (
    .tck     (ijtag_tck),
    .reset_n (ijtag_reset),
    .sel_nxt (sel_nxt),
    .ce_nxt  (ce_nxt),
    .se_nxt  (se_nxt),
    .ue_nxt  (ue_nxt),
    .si_nxt  (si_nxt),
    .sel     (ijtag_sel),
    .ce      (ijtag_ce),
    .se      (ijtag_se),
    .ue      (ijtag_ue),
    .si      (ijtag_si)
  );

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_ijtag_host_seq.sv
// Directed bench: SIB + 4-bit TDR network model and a 64-bit loopback delay line behind the host.
module tb_firebird7_in_gate1_tessent_ijtag_host_seq;
  import firebird7_in_gate1_ijtag_host_pkg::*;

  logic        ijtag_tck = 1'b0;
  logic        ijtag_reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  req_len = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic        ijtag_so;
  logic [4:0]  drv;

  int n_vec = 0;
  int n_miss = 0;

  firebird7_in_gate1_tessent_ijtag_host_seq dut (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_len     (req_len),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .ijtag_sel   (ijtag_sel),
    .ijtag_ce    (ijtag_ce),
    .ijtag_se    (ijtag_se),
    .ijtag_ue    (ijtag_ue),
    .ijtag_si    (ijtag_si),
    .ijtag_so    (ijtag_so)
  );

  always #5 ijtag_tck = ~ijtag_tck;
  assign drv = {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si};

  // Network model: net_mode 0 = SIB with a 4-bit TDR on its host port, 1 = 64-bit loopback.
  logic        net_mode = 1'b0;
  logic        sib_sr, sib_to_sel, so_q;
  logic [3:0]  tdr_sr, tdr_val;
  logic [63:0] dly;

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sib_sr <= 1'b0;
      tdr_sr <= '0;
      dly    <= '0;
    end else if (ijtag_sel) begin
      if (net_mode) begin
        if (ijtag_se) dly <= {ijtag_si, dly[63:1]};
      end else if (ijtag_ce) begin
        sib_sr <= sib_to_sel;
        if (sib_to_sel) tdr_sr <= tdr_val;
      end else if (ijtag_se) begin
        if (sib_to_sel) begin
          sib_sr <= tdr_sr[0];
          tdr_sr <= {ijtag_si, tdr_sr[3:1]};
        end else begin
          sib_sr <= ijtag_si;
        end
      end
    end
  end

  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sib_to_sel <= 1'b0;
      tdr_val    <= 4'b1010;
      so_q       <= 1'b0;
    end else begin
      so_q <= net_mode ? dly[0] : sib_sr;
      if (!net_mode && ijtag_sel && ijtag_ue) begin
        sib_to_sel <= sib_sr;
        if (sib_to_sel) tdr_val <= tdr_sr;
      end
    end
  end
  assign ijtag_so = so_q;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] len_mask(input logic [6:0] len);
    if (len >= 7'd64) return '1;
    return (64'd1 << len) - 64'd1;
  endfunction

  task automatic issue(input req_t r);
    int guard;
    guard = 0;
    @(negedge ijtag_tck);
    req_valid = 1'b1;
    req_len   = r.len;
    req_wdata = r.wdata;
    while (!req_ready && guard < 50) begin
      @(negedge ijtag_tck);
      guard++;
    end
    check_eq("accept_wait", 64'(guard < 50), 64'd1);
    @(posedge ijtag_tck);
    #1 req_valid = 1'b0;
  endtask

  // Starts just after the accepting edge; watches every falling edge up to rsp_valid.
  task automatic track(input req_t r);
    int lat, n_ce, n_se, n_ue, n_sel, bad;
    logic [63:0] si_vec;
    logic legal;
    lat = 0; n_ce = 0; n_se = 0; n_ue = 0; n_sel = 0; bad = 0; si_vec = '0;
    legal = (r.len >= 7'd1) && (r.len <= 7'd64);
    while (!rsp_valid && lat < 200) begin
      @(negedge ijtag_tck);
      #1;
      if (ijtag_sel) n_sel++;
      if (ijtag_ce) n_ce++;
      if (ijtag_ue) n_ue++;
      if (ijtag_se) begin
        si_vec = si_vec | (64'(ijtag_si) << n_se);
        n_se++;
      end
      if ((int'(ijtag_ce) + int'(ijtag_se) + int'(ijtag_ue)) > 1) bad++;
      if (!ijtag_sel && (ijtag_ce || ijtag_se || ijtag_ue)) bad++;
      if (!ijtag_se && ijtag_si) bad++;
      @(posedge ijtag_tck);
      #1 lat++;
    end
    check_eq("latency", 64'(lat), legal ? 64'(r.len) + 64'd3 : 64'd1);
    check_eq("sel_cycles", 64'(n_sel), legal ? 64'(r.len) + 64'd2 : 64'd0);
    check_eq("ce_cycles", 64'(n_ce), legal ? 64'd1 : 64'd0);
    check_eq("se_cycles", 64'(n_se), legal ? 64'(r.len) : 64'd0);
    check_eq("ue_cycles", 64'(n_ue), legal ? 64'd1 : 64'd0);
    check_eq("drive_exclusive", 64'(bad), 64'd0);
    check_eq("si_stream", si_vec, legal ? (r.wdata & len_mask(r.len)) : 64'd0);
  endtask

  task automatic respond(input int hold, input logic [63:0] exp_rdata, input logic exp_err);
    check_eq("rsp_rdata", rsp_rdata, exp_rdata);
    check_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge ijtag_tck);
      #1;
      check_eq("hold_valid", 64'(rsp_valid), 64'd1);
      check_eq("hold_rdata", rsp_rdata, exp_rdata);
      check_eq("hold_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge ijtag_tck);
    rsp_ready = 1'b1;
    @(posedge ijtag_tck);
    #1 rsp_ready = 1'b0;
    check_eq("rsp_cleared", 64'(rsp_valid), 64'd0);
  endtask

  task automatic run(input req_t r, input logic [63:0] exp_rdata, input logic exp_err);
    issue(r);
    track(r);
    respond(0, exp_rdata, exp_err);
  endtask

  logic [63:0] walk [3];
  logic [63:0] prev;
  int          vcount;

  initial begin
    walk[0] = 64'h0000_0000_0000_0001;
    walk[1] = 64'h0000_0000_8000_0000;
    walk[2] = 64'h8000_0000_0000_0000;

    // Reset and idle
    #7;
    check_eq("reset_drive", 64'(drv), 64'd0);
    check_eq("reset_req_ready", 64'(req_ready), 64'd0);
    check_eq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("reset_rdata", rsp_rdata, 64'd0);
    check_eq("reset_err", 64'(rsp_err), 64'd0);
    #5 ijtag_reset = 1'b1;
    @(posedge ijtag_tck);
    #1;
    check_eq("idle_req_ready", 64'(req_ready), 64'd1);
    check_eq("idle_drive", 64'(drv), 64'd0);

    // Abort with reset during the 3rd shift bit of an 8-bit access
    issue('{len: 7'd8, wdata: 64'hFF});
    repeat (4) @(negedge ijtag_tck);
    #3;
    check_eq("mid_shift_se", 64'(ijtag_se), 64'd1);
    ijtag_reset = 1'b0;
    #1;
    check_eq("abort_drive", 64'(drv), 64'd0);
    check_eq("abort_req_ready", 64'(req_ready), 64'd0);
    #10 ijtag_reset = 1'b1;
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge ijtag_tck);
      #1;
      if (rsp_valid) vcount++;
    end
    check_eq("abort_no_rsp", 64'(vcount), 64'd0);
    check_eq("abort_req_ready_back", 64'(req_ready), 64'd1);

    // Closed SIB, one bit: captures 0, opens the SIB on update
    run('{len: 7'd1, wdata: 64'h1}, 64'h0, 1'b0);
    check_eq("sib_to_sel_open", 64'(sib_to_sel), 64'd1);

    // Open SIB with TDR = 1010 behind it
    run('{len: 7'd5, wdata: 64'h01}, 64'h15, 1'b0);
    check_eq("tdr_update_0", 64'(tdr_val), 64'h0);
    run('{len: 7'd5, wdata: 64'h17}, 64'h01, 1'b0);
    check_eq("tdr_update_1", 64'(tdr_val), 64'hB);
    check_eq("sib_still_open", 64'(sib_to_sel), 64'd1);

    // Illegal lengths
    run('{len: 7'd0, wdata: 64'hFFFF}, 64'h0, 1'b1);
    run('{len: 7'd65, wdata: 64'hFFFF}, 64'h0, 1'b1);

    // Full-length walking ones through the loopback; each read returns the previous write
    net_mode = 1'b1;
    prev = '0;
    for (int k = 0; k < 3; k++) begin
      run('{len: 7'd64, wdata: walk[k]}, prev, 1'b0);
      prev = walk[k];
    end

    // Backpressure: response held 10 cycles while a second request waits
    issue('{len: 7'd64, wdata: 64'hDEAD_BEEF_0123_4567});
    track('{len: 7'd64, wdata: 64'hDEAD_BEEF_0123_4567});
    check_eq("bp_rdata", rsp_rdata, walk[2]);
    for (int i = 0; i < 10; i++) begin
      @(posedge ijtag_tck);
      #1;
      if (i == 2) begin
        req_valid = 1'b1;
        req_len   = 7'd2;
        req_wdata = 64'h0;
      end
      check_eq("bp_valid", 64'(rsp_valid), 64'd1);
      check_eq("bp_rdata_hold", rsp_rdata, walk[2]);
      check_eq("bp_req_ready", 64'(req_ready), 64'd0);
      check_eq("bp_sel", 64'(ijtag_sel), 64'd0);
    end
    @(negedge ijtag_tck);
    rsp_ready = 1'b1;
    @(posedge ijtag_tck);
    #1 rsp_ready = 1'b0;
    check_eq("bp_rsp_cleared", 64'(rsp_valid), 64'd0);
    check_eq("bp_ready_after_hs", 64'(req_ready), 64'd1);
    @(posedge ijtag_tck);
    #1;
    check_eq("bp_accepted", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    track('{len: 7'd2, wdata: 64'h0});
    respond(0, 64'h3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
